// File: rtl/gen_fifo_defines_pkg.sv
// gen_fifo_defines_pkg: shared types and widths for the generator run sequencer.
//   SEQ_CNT_W   : default sample counter width
//   seq_state_t : sequencer FSM states
package gen_fifo_defines_pkg;
    parameter int SEQ_CNT_W = 16;
    typedef enum logic [2:0] {S_IDLE, S_CFG, S_RUN, S_PAUSE, S_DONE} seq_state_t;
endpackage

// File: rtl/gen_seq_counter.sv
// gen_seq_counter: loadable down-counter with zero flag, saturating at zero.
//   clk, rst   : clock, asynchronous active-low reset
//   load       : load load_val (wins over dec)
//   dec        : decrement by one while non-zero
//   cnt, zero  : current value and cnt==0 flag
module gen_seq_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic         zero
);
    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (dec && !zero) cnt <= cnt - W'(1);
    assign zero = cnt == '0;
endmodule

// File: rtl/gen_run_sequencer.sv
// gen_run_sequencer: sequences one generator run (config, generate N samples, done).
//   clk, rst              : clock, asynchronous active-low reset
//   start_i, abort_i      : host run control
//   num_samples_i         : run length, latched on accepted start
//   gen_valid_i           : generator wrote a sample this cycle
//   fifo_afull_i/full_i   : FIFO back-pressure status
//   enh_conf_o, en_low_o  : generator FSM control
//   busy_o, done_o, aborted_o, overflow_o, sample_cnt_o : host status
module gen_run_sequencer
    import gen_fifo_defines_pkg::*;
#(
    parameter int CNT_W      = SEQ_CNT_W,
    parameter int CFG_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [CNT_W-1:0] num_samples_i,
    input  logic             gen_valid_i,
    input  logic             fifo_afull_i,
    input  logic             fifo_full_i,
    output logic             enh_conf_o,
    output logic             en_low_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             aborted_o,
    output logic             overflow_o,
    output logic [CNT_W-1:0] sample_cnt_o
);
    localparam int CFG_W = $clog2(CFG_CYCLES + 1);
    seq_state_t state, state_next;
    logic [CNT_W-1:0] target;
    logic [CFG_W-1:0] cfg_cnt;
    logic cfg_zero, accept, abort, cnt_en, last, cfg_load;
    assign accept   = state == S_IDLE && start_i;
    assign abort    = abort_i && state != S_IDLE;
    assign cnt_en   = state inside {S_CFG, S_RUN, S_PAUSE};
    assign last     = cnt_en && gen_valid_i && sample_cnt_o == target - CNT_W'(1);
    // cfg phase is (re)entered from IDLE on a non-empty start or on leaving a pause
    assign cfg_load = state_next == S_CFG && state != S_CFG;
    gen_seq_counter #(.W(CFG_W)) u_cfg_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cfg_load),
        .dec      (state == S_CFG),
        .load_val (CFG_W'(CFG_CYCLES - 1)),
        .cnt      (cfg_cnt),
        .zero     (cfg_zero)
    );
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= S_IDLE;
        else state <= state_next;
    // completion beats pause, abort beats everything
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start_i) state_next = num_samples_i != '0 ? S_CFG : S_DONE;
            S_CFG:   state_next = last ? S_DONE : cfg_zero ? S_RUN : S_CFG;
            S_RUN:   state_next = last ? S_DONE : fifo_afull_i ? S_PAUSE : S_RUN;
            S_PAUSE: state_next = last ? S_DONE : fifo_afull_i ? S_PAUSE : S_CFG;
            default: state_next = S_IDLE;
        endcase
        if (abort) state_next = S_IDLE;
    end
    always_comb begin
        enh_conf_o = state == S_CFG;
        en_low_o   = state != S_RUN;
        busy_o     = state != S_IDLE;
        done_o     = state == S_DONE;
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            target       <= '0;
            sample_cnt_o <= '0;
            aborted_o    <= 1'b0;
            overflow_o   <= 1'b0;
        end else begin
            aborted_o <= abort;
            if (accept) target <= num_samples_i;
            if (accept) sample_cnt_o <= '0;
            else if (cnt_en && gen_valid_i && !abort_i && sample_cnt_o != target)
                sample_cnt_o <= sample_cnt_o + CNT_W'(1);
            overflow_o <= (overflow_o && !accept) || (gen_valid_i && fifo_full_i);
        end
endmodule

// File: tb/tb_gen_run_sequencer.sv
// tb_gen_run_sequencer: scoreboard bench for gen_run_sequencer (CFG_CYCLES=4).
module tb_gen_run_sequencer;
    logic clk = 1'b0, rst, start_i, abort_i, gen_valid_i, fifo_afull_i, fifo_full_i;
    logic [15:0] num_samples_i, sample_cnt_o;
    logic enh_conf_o, en_low_o, busy_o, done_o, aborted_o, overflow_o;
    int n_vec = 0, n_err = 0, n;
    typedef struct packed {logic ab; logic [15:0] cnt;} ev_t;
    ev_t sb[$];
    ev_t e_mon;

    always #5 clk = ~clk;

    gen_run_sequencer #(.CNT_W(16), .CFG_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
        .num_samples_i(num_samples_i), .gen_valid_i(gen_valid_i),
        .fifo_afull_i(fifo_afull_i), .fifo_full_i(fifo_full_i),
        .enh_conf_o(enh_conf_o), .en_low_o(en_low_o), .busy_o(busy_o),
        .done_o(done_o), .aborted_o(aborted_o), .overflow_o(overflow_o),
        .sample_cnt_o(sample_cnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input logic ab, input logic [15:0] cnt);
        sb.push_back(ev_t'{ab: ab, cnt: cnt});
    endtask

    task automatic start_run(input logic [15:0] num);
        start_i = 1'b1;
        num_samples_i = num;
        tick;
        start_i = 1'b0;
    endtask

    // counts enh_conf_o cycles until the generator is released (en_low_o low)
    task automatic wait_run(output int cfg_n);
        cfg_n = 0;
        for (int i = 0; i < 20 && en_low_o; i++) begin
            if (enh_conf_o) cfg_n++;
            tick;
        end
        if (en_low_o) chk("run_timeout", 32'd0, 32'd1);
    endtask

    task automatic valids(input int k);
        gen_valid_i = 1'b1;
        repeat (k) tick;
        gen_valid_i = 1'b0;
    endtask

    always @(negedge clk)
        if (rst && (done_o || aborted_o)) begin
            if (sb.size() == 0) chk("sb_unexpected", {done_o, aborted_o}, 2'b00);
            else begin
                e_mon = sb.pop_front();
                chk("sb_aborted", aborted_o, e_mon.ab);
                chk("sb_done", done_o, !e_mon.ab);
                chk("sb_cnt", sample_cnt_o, e_mon.cnt);
            end
        end

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        rst = 1'b0; start_i = 1'b0; abort_i = 1'b0; num_samples_i = '0;
        gen_valid_i = 1'b0; fifo_afull_i = 1'b0; fifo_full_i = 1'b0;
        #3;
        chk("rst_en_low", en_low_o, 1);
        chk("rst_enh_conf", enh_conf_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_aborted", aborted_o, 0);
        chk("rst_overflow", overflow_o, 0);
        chk("rst_cnt", sample_cnt_o, 0);
        @(negedge clk) rst = 1'b1;
        tick;
        // basic run of 3
        expect_ev(0, 3);
        start_run(3);
        chk("basic_conf_lat", enh_conf_o, 1);
        chk("basic_busy", busy_o, 1);
        wait_run(n);
        chk("basic_cfg_len", n, 4);
        valids(3);
        chk("basic_done", done_o, 1);
        chk("basic_cnt", sample_cnt_o, 3);
        tick;
        chk("basic_done_fall", done_o, 0);
        chk("basic_busy_fall", busy_o, 0);
        // pause with an in-flight sample
        expect_ev(0, 5);
        start_run(5);
        wait_run(n);
        valids(2);
        fifo_afull_i = 1'b1;
        tick;
        chk("pause_en_low", en_low_o, 1);
        chk("pause_enh_conf", enh_conf_o, 0);
        valids(1);
        chk("pause_cnt", sample_cnt_o, 3);
        tick;
        chk("pause_hold", en_low_o, 1);
        fifo_afull_i = 1'b0;
        tick;
        chk("resume_cfg", enh_conf_o, 1);
        wait_run(n);
        chk("resume_cfg_len", n, 4);
        valids(2);
        chk("pause_done", done_o, 1);
        tick;
        // last sample coincides with afull
        expect_ev(0, 2);
        start_run(2);
        wait_run(n);
        valids(1);
        gen_valid_i = 1'b1; fifo_afull_i = 1'b1;
        tick;
        gen_valid_i = 1'b0; fifo_afull_i = 1'b0;
        chk("last_afull_done", done_o, 1);
        tick;
        chk("last_afull_idle", busy_o, 0);
        // abort mid-run at 7 of 10
        expect_ev(1, 7);
        start_run(10);
        wait_run(n);
        valids(7);
        abort_i = 1'b1;
        tick;
        abort_i = 1'b0;
        chk("abort_pulse", aborted_o, 1);
        chk("abort_no_done", done_o, 0);
        chk("abort_cnt", sample_cnt_o, 7);
        chk("abort_busy", busy_o, 0);
        tick;
        chk("abort_pulse_end", aborted_o, 0);
        // abort together with the final sample
        expect_ev(1, 1);
        start_run(2);
        wait_run(n);
        valids(1);
        gen_valid_i = 1'b1; abort_i = 1'b1;
        tick;
        gen_valid_i = 1'b0; abort_i = 1'b0;
        chk("abort_last_pulse", aborted_o, 1);
        chk("abort_last_no_done", done_o, 0);
        tick;
        chk("abort_last_no_done2", done_o, 0);
        // zero-length run
        expect_ev(0, 0);
        start_run(0);
        chk("zero_done", done_o, 1);
        chk("zero_no_conf", enh_conf_o, 0);
        tick;
        chk("zero_idle", busy_o, 0);
        chk("zero_no_conf2", enh_conf_o, 0);
        // overflow sticky until next start
        gen_valid_i = 1'b1; fifo_full_i = 1'b1;
        tick;
        gen_valid_i = 1'b0; fifo_full_i = 1'b0;
        chk("ovf_set", overflow_o, 1);
        chk("ovf_idle_nocount", sample_cnt_o, 0);
        repeat (3) tick;
        chk("ovf_held", overflow_o, 1);
        expect_ev(0, 1);
        start_run(1);
        chk("ovf_cleared", overflow_o, 0);
        wait_run(n);
        valids(1);
        chk("ovf_run_done", done_o, 1);
        tick;
        // start while busy is ignored
        expect_ev(0, 4);
        start_run(4);
        start_i = 1'b1; num_samples_i = 16'd1;
        tick;
        start_i = 1'b0;
        wait_run(n);
        valids(1);
        chk("busy_start_no_done", done_o, 0);
        valids(3);
        chk("busy_start_done", done_o, 1);
        chk("busy_start_cnt", sample_cnt_o, 4);
        tick;
        // asynchronous reset mid-run
        start_run(5);
        wait_run(n);
        valids(2);
        rst = 1'b0;
        #1;
        chk("arst_busy", busy_o, 0);
        chk("arst_cnt", sample_cnt_o, 0);
        chk("arst_en_low", en_low_o, 1);
        @(negedge clk) rst = 1'b1;
        repeat (3) tick;
        chk("sb_left", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
